// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the requester-side and SRAM-side signals of sram_arbiter.
//   Fetch port : if_ce_i, if_addr_i -> if_data_o, if_ready_o
//   Data port  : mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i
//                -> mem_data_o, mem_ready_o
//   Control    : stallreq_o (stall request towards the pipeline controller)
//   SRAM       : sram_addr_o, sram_wdata_o, sram_ce_n_o, sram_oe_n_o,
//                sram_we_n_o, sram_be_n_o (all strobes active-low) and
//                sram_rdata_i
// Modport slave is the arbiter; modport master is the pipeline plus the SRAM.
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int SRAM_AW = 20
);
    logic               if_ce_i;
    logic [31:0]        if_addr_i;
    logic [31:0]        if_data_o;
    logic               if_ready_o;

    logic               mem_ce_i;
    logic               mem_we_i;
    logic [31:0]        mem_addr_i;
    logic [31:0]        mem_data_i;
    logic [3:0]         mem_sel_i;
    logic [31:0]        mem_data_o;
    logic               mem_ready_o;

    logic               stallreq_o;

    logic [SRAM_AW-1:0] sram_addr_o;
    logic [31:0]        sram_wdata_o;
    logic [31:0]        sram_rdata_i;
    logic               sram_ce_n_o;
    logic               sram_oe_n_o;
    logic               sram_we_n_o;
    logic [3:0]         sram_be_n_o;

    modport slave (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_ready_o,
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
        output mem_data_o, mem_ready_o,
        output stallreq_o,
        output sram_addr_o, sram_wdata_o,
        input  sram_rdata_i,
        output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

    modport master (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_ready_o,
        output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
        input  mem_data_o, mem_ready_o,
        input  stallreq_o,
        input  sram_addr_o, sram_wdata_o,
        output sram_rdata_i,
        input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous SRAM between the instruction-fetch port and the data
// port. Each access occupies the ACCESS state for WAIT_CYCLES+1 cycles, then
// the owner gets its read data and a one-cycle ready pulse. The data port wins
// when both request in the same cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : sram_arbiter_if.slave (requester ports, stall request, SRAM pins)
// All SRAM pins, ready pulses and read-data outputs are registered; only
// stallreq_o is combinational.
// SRAM_AW must not exceed 29 (word address taken from addr[SRAM_AW+1:2]).
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus
);

    localparam int             CW      = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0]  LP_WAIT = CW'(WAIT_CYCLES);
    localparam logic           OWN_IF  = 1'b0;
    localparam logic           OWN_MEM = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // FSM and captured request
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_owner;
    logic               r_we;
    logic [SRAM_AW-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_sel_be_n;

    // registered outputs
    logic [31:0]        r_if_data;
    logic [31:0]        r_mem_data;
    logic               r_if_ready;
    logic               r_mem_ready;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic [3:0]         r_be_n;

    // next-state values
    state_t             w_nxt_state;
    logic [CW-1:0]      w_nxt_cnt;
    logic               w_nxt_owner;
    logic               w_nxt_we;
    logic [SRAM_AW-1:0] w_nxt_addr;
    logic [31:0]        w_nxt_wdata;
    logic [3:0]         w_nxt_sel_be_n;
    logic               w_done;

    // next output values
    logic [31:0]        w_nxt_if_data;
    logic [31:0]        w_nxt_mem_data;
    logic               w_nxt_if_ready;
    logic               w_nxt_mem_ready;
    logic               w_nxt_ce_n;
    logic               w_nxt_oe_n;
    logic               w_nxt_we_n;
    logic [3:0]         w_nxt_be_n;

    logic               w_idle_free;
    logic               w_grant_mem;
    logic               w_grant_if;
    logic               w_unused_addr;

    // A ready pulse in flight blocks granting, so the requester that is just
    // being answered cannot be served a second time off the same request.
    assign w_idle_free = (r_state == ST_IDLE) && !r_if_ready && !r_mem_ready;
    assign w_grant_mem = w_idle_free && bus.mem_ce_i;
    assign w_grant_if  = w_idle_free && !bus.mem_ce_i && bus.if_ce_i;

    // Byte-offset and high address bits do not reach the SRAM.
    assign w_unused_addr = ^{bus.if_addr_i[31:SRAM_AW+2],  bus.if_addr_i[1:0],
                             bus.mem_addr_i[31:SRAM_AW+2], bus.mem_addr_i[1:0]};

    // State register and captured request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0000_0000;
            r_sel_be_n <= 4'b1111;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_owner    <= w_nxt_owner;
            r_we       <= w_nxt_we;
            r_addr     <= w_nxt_addr;
            r_wdata    <= w_nxt_wdata;
            r_sel_be_n <= w_nxt_sel_be_n;
        end
    end

    // Next-state logic: grant in IDLE, count wait states in ACCESS
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_owner    = r_owner;
        w_nxt_we       = r_we;
        w_nxt_addr     = r_addr;
        w_nxt_wdata    = r_wdata;
        w_nxt_sel_be_n = r_sel_be_n;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_mem) begin
                    w_nxt_state    = ST_ACCESS;
                    w_nxt_cnt      = '0;
                    w_nxt_owner    = OWN_MEM;
                    w_nxt_we       = bus.mem_we_i;
                    w_nxt_addr     = bus.mem_addr_i[SRAM_AW+1:2];
                    w_nxt_wdata    = bus.mem_data_i;
                    w_nxt_sel_be_n = ~bus.mem_sel_i;
                end else if (w_grant_if) begin
                    w_nxt_state    = ST_ACCESS;
                    w_nxt_cnt      = '0;
                    w_nxt_owner    = OWN_IF;
                    w_nxt_we       = 1'b0;
                    w_nxt_addr     = bus.if_addr_i[SRAM_AW+1:2];
                    w_nxt_sel_be_n = 4'b0000;
                end else begin
                    w_nxt_state    = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == LP_WAIT) begin
                    w_done      = 1'b1;
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt   = r_cnt + CW'(1'b1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Output logic: strobes follow the next state so the registered pins line
    // up with the cycles spent in ACCESS
    always_comb begin
        w_nxt_ce_n      = 1'b1;
        w_nxt_oe_n      = 1'b1;
        w_nxt_we_n      = 1'b1;
        w_nxt_be_n      = 4'b1111;
        w_nxt_if_ready  = 1'b0;
        w_nxt_mem_ready = 1'b0;
        w_nxt_if_data   = r_if_data;
        w_nxt_mem_data  = r_mem_data;
        if (w_nxt_state == ST_ACCESS) begin
            w_nxt_ce_n = 1'b0;
            if (w_nxt_we) begin
                w_nxt_be_n = w_nxt_sel_be_n;
                // release WE one cycle early to give the SRAM hold time
                w_nxt_we_n = (w_nxt_cnt < LP_WAIT) ? 1'b0 : 1'b1;
            end else begin
                w_nxt_oe_n = 1'b0;
                w_nxt_be_n = 4'b0000;
            end
        end else begin
            w_nxt_ce_n = 1'b1;
        end
        if (w_done) begin
            if (r_owner == OWN_MEM) begin
                w_nxt_mem_ready = 1'b1;
                w_nxt_mem_data  = r_we ? r_mem_data : bus.sram_rdata_i;
            end else begin
                w_nxt_if_ready  = 1'b1;
                w_nxt_if_data   = r_we ? r_if_data : bus.sram_rdata_i;
            end
        end else begin
            w_nxt_if_ready  = 1'b0;
            w_nxt_mem_ready = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_data   <= 32'h0000_0000;
            r_mem_data  <= 32'h0000_0000;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= 4'b1111;
        end else begin
            r_if_data   <= w_nxt_if_data;
            r_mem_data  <= w_nxt_mem_data;
            r_if_ready  <= w_nxt_if_ready;
            r_mem_ready <= w_nxt_mem_ready;
            r_ce_n      <= w_nxt_ce_n;
            r_oe_n      <= w_nxt_oe_n;
            r_we_n      <= w_nxt_we_n;
            r_be_n      <= w_nxt_be_n;
        end
    end

    assign bus.if_data_o    = r_if_data;
    assign bus.if_ready_o   = r_if_ready;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.mem_ready_o  = r_mem_ready;
    assign bus.sram_addr_o  = r_addr;
    assign bus.sram_wdata_o = r_wdata;
    assign bus.sram_ce_n_o  = r_ce_n;
    assign bus.sram_oe_n_o  = r_oe_n;
    assign bus.sram_we_n_o  = r_we_n;
    assign bus.sram_be_n_o  = r_be_n;

    // A requester stalls the pipeline until the cycle its ready pulse shows.
    assign bus.stallreq_o = (bus.if_ce_i  & ~r_if_ready) |
                            (bus.mem_ce_i & ~r_mem_ready);

endmodule
